// File: rtl/serial_min3_pkg.sv
// Shared types and constants for the bit-serial minimum-of-three transmit path.
//
// Contents:
//   state_t        - transmitter FSM state (IDLE, SHIFT, GAP)
//   DEFAULT_WIDTH  - default operand width in bits (and beats per frame)
//   FRAMES_W       - width of the completed-frame counter
//   GAP_CNT_W      - width of the inter-frame gap counter (holds up to 15)
package serial_min3_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned FRAMES_W      = 8;
    localparam int unsigned GAP_CNT_W     = 4;

endpackage

// File: rtl/piso_lane.sv
// Parallel-in serial-out lane register, MSB first.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset, clears the register
//   load   in   capture din (takes priority over shift)
//   shift  in   shift left by one, filling with 0
//   din    in   WIDTH-bit parallel operand
//   dout   out  current MSB of the register
//
// Zero fill means the register is empty once all WIDTH bits have gone out,
// so dout is 0 whenever no frame is in flight without any extra gating.
module piso_lane
    import serial_min3_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
        end
    end

    assign dout = sr[WIDTH-1];

endmodule

// File: rtl/serial_min3_tx.sv
// Transmit side of the bit-serial minimum-of-three interface.
//
// Accepts a parallel triple (a, b, c) on a valid/ready handshake and shifts the
// three operands out MSB-first on three 1-bit lanes, one bit per beat, with a
// per-beat valid/ready handshake and first/last markers. After each frame the
// block idles for GAP_CYCLES cycles before it accepts the next triple.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   in_valid     in   parallel triple offered
//   in_ready     out  block can accept a triple (combinational: IDLE and not rst)
//   a, b, c      in   WIDTH-bit operands, sampled only at the accepting edge
//   ser_a/b/c    out  current bit of each lane, 0 when ser_valid is low
//   ser_valid    out  lane bits valid
//   ser_first    out  current beat is bit WIDTH-1
//   ser_last     out  current beat is bit 0
//   ser_ready    in   downstream consumes the current beat
//   busy         out  frame in SHIFT or GAP
//   frames_sent  out  completed frames, wraps modulo 256
module serial_min3_tx
    import serial_min3_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [WIDTH-1:0]    c,
    output logic                ser_a,
    output logic                ser_b,
    output logic                ser_c,
    output logic                ser_valid,
    output logic                ser_first,
    output logic                ser_last,
    input  logic                ser_ready,
    output logic                busy,
    output logic [FRAMES_W-1:0] frames_sent
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    // Gap counter is loaded with GAP_CYCLES-1 and leaves GAP on reaching 0.
    localparam logic [GAP_CNT_W-1:0] GAP_LAST =
        GAP_CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_t               state;
    logic [IDX_W-1:0]     bit_idx;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic                 accept;
    logic                 beat_xfer;

    assign in_ready  = (state == IDLE) & ~rst;
    assign accept    = in_valid & in_ready;
    assign beat_xfer = ser_valid & ser_ready;

    piso_lane #(
        .WIDTH (WIDTH)
    ) u_lane_a (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (beat_xfer),
        .din   (a),
        .dout  (ser_a)
    );

    piso_lane #(
        .WIDTH (WIDTH)
    ) u_lane_b (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (beat_xfer),
        .din   (b),
        .dout  (ser_b)
    );

    piso_lane #(
        .WIDTH (WIDTH)
    ) u_lane_c (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (beat_xfer),
        .din   (c),
        .dout  (ser_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_idx     <= '0;
            gap_cnt     <= '0;
            ser_valid   <= 1'b0;
            ser_first   <= 1'b0;
            ser_last    <= 1'b0;
            busy        <= 1'b0;
            frames_sent <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= SHIFT;
                        bit_idx   <= IDX_MSB;
                        ser_valid <= 1'b1;
                        ser_first <= 1'b1;
                        ser_last  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                SHIFT: begin
                    // Without a transfer everything holds, which keeps the beat stable.
                    if (beat_xfer) begin
                        if (bit_idx == '0) begin
                            frames_sent <= frames_sent + 1'b1;
                            ser_valid   <= 1'b0;
                            ser_first   <= 1'b0;
                            ser_last    <= 1'b0;
                            if (GAP_CYCLES > 0) begin
                                state   <= GAP;
                                gap_cnt <= GAP_LAST;
                            end else begin
                                state   <= IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            bit_idx   <= bit_idx - 1'b1;
                            ser_first <= 1'b0;
                            ser_last  <= (bit_idx == IDX_ONE);
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_min3_tx.sv
// Self-checking bench for serial_min3_tx: one instance at the default gap and
// one with GAP_CYCLES=0. Cycle tables cover the basic and backpressured frames;
// hand-written sequences cover back-to-back, reset mid-frame, counter wrap and
// the zero-gap period.
module tb_serial_min3_tx;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance (WIDTH=8, GAP_CYCLES=1)
    logic       rst, in_valid, in_ready, ser_ready;
    logic [7:0] a, b, c;
    logic       ser_a, ser_b, ser_c, ser_valid, ser_first, ser_last, busy;
    logic [7:0] frames_sent;

    // Zero-gap instance
    logic       rst1, in_valid1, in_ready1, ser_ready1;
    logic [7:0] a1, b1, c1;
    logic       ser_a1, ser_b1, ser_c1, ser_valid1, ser_first1, ser_last1, busy1;
    logic [7:0] frames_sent1;

    serial_min3_tx #(
        .WIDTH      (8),
        .GAP_CYCLES (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .c           (c),
        .ser_a       (ser_a),
        .ser_b       (ser_b),
        .ser_c       (ser_c),
        .ser_valid   (ser_valid),
        .ser_first   (ser_first),
        .ser_last    (ser_last),
        .ser_ready   (ser_ready),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    serial_min3_tx #(
        .WIDTH      (8),
        .GAP_CYCLES (0)
    ) dut_g0 (
        .clk         (clk),
        .rst         (rst1),
        .in_valid    (in_valid1),
        .in_ready    (in_ready1),
        .a           (a1),
        .b           (b1),
        .c           (c1),
        .ser_a       (ser_a1),
        .ser_b       (ser_b1),
        .ser_c       (ser_c1),
        .ser_valid   (ser_valid1),
        .ser_first   (ser_first1),
        .ser_last    (ser_last1),
        .ser_ready   (ser_ready1),
        .busy        (busy1),
        .frames_sent (frames_sent1)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One table row = inputs for one cycle, in_ready expected before the edge,
    // registered outputs expected after it.
    typedef struct {
        logic       rst, iv, sr;
        logic [7:0] a, b, c;
        logic       e_inrdy;
        logic [2:0] e_lanes;
        logic       e_v, e_f, e_l, e_busy;
        logic [7:0] e_fs;
    } vec_t;

    function automatic vec_t mk(input logic r, iv, sr, input logic [7:0] va, vb, vc,
                                input logic inrdy, input logic [2:0] lanes,
                                input logic v, f, l, bz, input logic [7:0] fs);
        vec_t t;
        t.rst = r; t.iv = iv; t.sr = sr; t.a = va; t.b = vb; t.c = vc;
        t.e_inrdy = inrdy; t.e_lanes = lanes;
        t.e_v = v; t.e_f = f; t.e_l = l; t.e_busy = bz; t.e_fs = fs;
        return t;
    endfunction

    // Checks a frame starting just after its accepting edge, at each negedge
    // before edges 1..period; in_ready expected high only before the last one.
    task automatic frame_check(input string tag, input logic [7:0] ea, eb, ec,
                               input int period, input logic rdy_at_end);
        int idx;
        for (int t = 1; t <= period; t++) begin
            @(negedge clk);
            #1;
            if (t <= 8) begin
                idx = 8 - t;
                chk($sformatf("%s_t%0d_lanes", tag, t), {ser_a, ser_b, ser_c},
                    {ea[idx], eb[idx], ec[idx]});
                chk($sformatf("%s_t%0d_vfl", tag, t), {ser_valid, ser_first, ser_last},
                    {1'b1, (t == 1), (t == 8)});
            end else begin
                chk($sformatf("%s_t%0d_idle", tag, t),
                    {ser_valid, ser_a, ser_b, ser_c}, 4'b0000);
            end
            chk($sformatf("%s_t%0d_in_ready", tag, t), in_ready,
                rdy_at_end && (t == period));
        end
    endtask

    vec_t tbl[$];
    int   acc_t[$];
    logic vh[0:39];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat;
        logic [7:0] prev;
        int         waitc;

        rst = 1'b1; in_valid = 1'b0; ser_ready = 1'b1; a = '0; b = '0; c = '0;
        rst1 = 1'b1; in_valid1 = 1'b0; ser_ready1 = 1'b1; a1 = '0; b1 = '0; c1 = '0;

        // Test 1: basic frame a=b=22, c=9
        tbl.push_back(mk(1, 0, 1, 22, 22, 9, 0, 3'b000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 22, 22, 9, 0, 3'b000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 22, 22, 9, 1, 3'b000, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 22, 22, 9, 0, 3'b000, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 22, 22, 9, 0, 3'b000, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 22, 22, 9, 0, 3'b110, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 22, 22, 9, 0, 3'b001, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 22, 22, 9, 0, 3'b110, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 22, 22, 9, 0, 3'b110, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 22, 22, 9, 0, 3'b001, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 22, 22, 9, 0, 3'b000, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 22, 22, 9, 0, 3'b000, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 22, 22, 9, 1, 3'b000, 0, 0, 0, 0, 1));
        // Test 2: backpressure on beat 3; operands scrambled after acceptance
        tbl.push_back(mk(0, 1, 1, 22, 22, 9, 1, 3'b000, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 255, 255, 255, 0, 3'b000, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 255, 255, 255, 0, 3'b000, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 255, 255, 255, 0, 3'b000, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 255, 255, 255, 0, 3'b000, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 255, 255, 255, 0, 3'b110, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 255, 255, 255, 0, 3'b001, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 255, 255, 255, 0, 3'b110, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 255, 255, 255, 0, 3'b110, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 255, 255, 255, 0, 3'b001, 1, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 1, 255, 255, 255, 0, 3'b000, 0, 0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 1, 255, 255, 255, 0, 3'b000, 0, 0, 0, 0, 2));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; in_valid = tbl[i].iv; ser_ready = tbl[i].sr;
            a = tbl[i].a; b = tbl[i].b; c = tbl[i].c;
            if (i == 2) rst1 = 1'b0;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_inrdy);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_outs", i),
                {ser_a, ser_b, ser_c, ser_valid, ser_first, ser_last, busy, frames_sent},
                {tbl[i].e_lanes, tbl[i].e_v, tbl[i].e_f, tbl[i].e_l, tbl[i].e_busy,
                 tbl[i].e_fs});
        end

        // Test 3: back-to-back with in_valid held
        @(negedge clk);
        in_valid = 1'b1; a = 8'd255; b = 8'd0; c = 8'd128; ser_ready = 1'b1;
        #1;
        chk("b2b_first_accept_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        a = 8'd1; b = 8'd2; c = 8'd3;
        frame_check("b2b1", 8'd255, 8'd0, 8'd128, 10, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = 8'd0; b = 8'd0; c = 8'd0;
        frame_check("b2b2", 8'd1, 8'd2, 8'd3, 10, 1'b1);
        chk("b2b_frames_sent", frames_sent, 8'd4);

        // Test 4: reset during beat 4 of a=170
        pat = 8'd170;
        @(negedge clk);
        in_valid = 1'b1; a = pat; b = 8'd0; c = 8'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rst_beat%0d", k), {ser_valid, ser_a}, {1'b1, pat[8-k]});
        end
        rst = 1'b1;
        #1;
        chk("rst_in_ready_low", in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_outs", {ser_valid, ser_first, ser_last, ser_a, busy, frames_sent},
            {5'b00000, 8'd0});
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready_after", in_ready, 1'b1);
        in_valid = 1'b1; a = pat; b = 8'd15; c = 8'd240;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        frame_check("rst_new", pat, 8'd15, 8'd240, 10, 1'b1);
        chk("rst_new_frames_sent", frames_sent, 8'd1);

        // Test 5: 256 frames, frames_sent goes ...254, 255, 0, 1
        @(negedge clk);
        in_valid = 1'b1; a = 8'h5A; b = 8'hA5; c = 8'h3C;
        prev = frames_sent;
        for (int n = 1; n <= 256; n++) begin
            waitc = 0;
            do begin
                @(negedge clk);
                #1;
                waitc++;
            end while (frames_sent == prev && waitc < 20);
            chk($sformatf("wrap_frame%0d", n), frames_sent, 8'(prev + 8'd1));
            prev = prev + 8'd1;
        end
        in_valid = 1'b0;
        chk("wrap_final", frames_sent, 8'd1);

        // Test 6: zero-gap instance under continuous traffic
        chk("g0_idle_frames", frames_sent1, 8'd0);
        @(negedge clk);
        in_valid1 = 1'b1; a1 = 8'hC3; b1 = 8'h0F; c1 = 8'hF0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            #1;
            if (in_ready1) acc_t.push_back(cyc);
            vh[cyc] = ser_valid1;
        end
        in_valid1 = 1'b0;
        chk("g0_accept_count", acc_t.size() >= 4, 1'b1);
        for (int i = 1; i < acc_t.size(); i++) begin
            chk($sformatf("g0_period%0d", i), acc_t[i] - acc_t[i-1], 9);
        end
        for (int cyc = 1; cyc < 39; cyc++) begin
            if (vh[cyc-1] && !vh[cyc]) begin
                chk($sformatf("g0_gap_at%0d", cyc), vh[cyc+1], 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
